// File: rtl/mul_div_unit.sv
// Iterative radix-2 RV32M multiply/divide engine that sits beside the execute-stage ALU.
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and multiply-by-zero finish at the accepting edge.

package mul_div_pkg;
  localparam logic [4:0] ALUCTRL_ADD    = 5'b00000;
  localparam logic [4:0] ALUCTRL_SUB    = 5'b00001;
  localparam logic [4:0] ALUCTRL_MUL    = 5'b10000;
  localparam logic [4:0] ALUCTRL_MULH   = 5'b10001;
  localparam logic [4:0] ALUCTRL_MULHSU = 5'b10010;
  localparam logic [4:0] ALUCTRL_MULHU  = 5'b10011;
  localparam logic [4:0] ALUCTRL_DIV    = 5'b10100;
  localparam logic [4:0] ALUCTRL_DIVU   = 5'b10101;
  localparam logic [4:0] ALUCTRL_REM    = 5'b10110;
  localparam logic [4:0] ALUCTRL_REMU   = 5'b10111;
endpackage

module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [4:0]      alu_ctrl,
  input  logic [BITS-1:0] op_a,
  input  logic [BITS-1:0] op_b,
  input  logic            flush,
  output logic            MulDivAluReady,
  output logic [BITS-1:0] result
);

  localparam int            CW        = $clog2(BITS);
  localparam logic [CW-1:0] LAST_ITER = CW'(BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4:0]        code_q, code_d;
  logic [BITS-1:0]   a_q, a_d;
  logic [BITS-1:0]   b_q, b_d;
  logic [BITS-1:0]   quo_q, quo_d;
  logic [BITS-1:0]   rem_q, rem_d;
  logic [BITS-1:0]   result_q, result_d;
  logic [2*BITS-1:0] prod_q, prod_d;
  logic              neg_q, neg_d;
  logic              sign_a_q, sign_a_d;
  logic              div_zero_q, div_zero_d;
  logic              ready_q, ready_d;

  logic            is_mul_in, is_div_in, sa_in, sb_in;
  logic [BITS-1:0] a_mag_in, b_mag_in;

  always_comb begin
    is_mul_in = alu_ctrl inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU};
    is_div_in = alu_ctrl inside {ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU};
    sa_in     = (alu_ctrl inside {ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_DIV, ALUCTRL_REM}) && op_a[BITS-1];
    sb_in     = (alu_ctrl inside {ALUCTRL_MULH, ALUCTRL_DIV, ALUCTRL_REM}) && op_b[BITS-1];
    a_mag_in  = sa_in ? -op_a : op_a;
    b_mag_in  = sb_in ? -op_b : op_b;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic            div_zero_in, ovf_in, mul_zero_in, early_hit;
  logic [BITS-1:0] early_result;

  always_comb begin
    div_zero_in  = is_div_in && (op_b == '0);
    ovf_in       = (alu_ctrl inside {ALUCTRL_DIV, ALUCTRL_REM}) &&
                   (op_a == {1'b1, {(BITS-1){1'b0}}}) && (op_b == '1);
    mul_zero_in  = is_mul_in && ((op_a == '0) || (op_b == '0));
    early_hit    = div_zero_in || ovf_in || mul_zero_in;
    early_result = '0;
    if (div_zero_in) begin
      early_result = (alu_ctrl inside {ALUCTRL_DIV, ALUCTRL_DIVU}) ? '1 : op_a;
    end else if (ovf_in) begin
      early_result = (alu_ctrl == ALUCTRL_DIV) ? {1'b1, {(BITS-1){1'b0}}} : '0;
    end
  end
`endif

  // One shift-add step and one restoring-division step, both on magnitudes.
  logic          is_mul_q;
  logic [BITS:0] mul_sum, div_shift, div_diff;

  always_comb begin
    is_mul_q  = code_q inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU};
    mul_sum   = {1'b0, prod_q[2*BITS-1:BITS]} + (prod_q[0] ? {1'b0, a_q} : '0);
    div_shift = {rem_q, quo_q[BITS-1]};
    div_diff  = div_shift - {1'b0, b_q};
  end

  logic [2*BITS-1:0] prod_fix;
  logic [BITS-1:0]   quo_fix, rem_fix, fix_result;

  always_comb begin
    prod_fix   = neg_q ? -prod_q : prod_q;
    quo_fix    = div_zero_q ? '1 : (neg_q ? -quo_q : quo_q);
    rem_fix    = sign_a_q ? -rem_q : rem_q;
    fix_result = rem_fix;
    case (code_q)
      ALUCTRL_MUL:                                   fix_result = prod_fix[BITS-1:0];
      ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU:   fix_result = prod_fix[2*BITS-1:BITS];
      ALUCTRL_DIV, ALUCTRL_DIVU:                     fix_result = quo_fix;
      default:                                       fix_result = rem_fix;
    endcase
  end

  always_comb begin
    // NOTE: every *_d takes its *_q value first, so no branch can leave a latch behind.
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    a_d        = a_q;
    b_d        = b_q;
    prod_d     = prod_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    neg_d      = neg_q;
    sign_a_d   = sign_a_q;
    div_zero_d = div_zero_q;
    result_d   = result_q;
    ready_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid && (is_mul_in || is_div_in)) begin
          code_d     = alu_ctrl;
          a_d        = a_mag_in;
          b_d        = b_mag_in;
          prod_d     = {{BITS{1'b0}}, b_mag_in};
          quo_d      = a_mag_in;
          rem_d      = '0;
          cnt_d      = '0;
          neg_d      = sa_in ^ sb_in;
          sign_a_d   = sa_in;
          div_zero_d = is_div_in && (op_b == '0);
          state_d    = S_BUSY;
`ifdef MULDIV_EARLY_OUT_EN
          if (early_hit) begin
            result_d = early_result;
            ready_d  = 1'b1;
            state_d  = S_DONE;
          end
`endif
        end
      end
      S_BUSY: begin
        if (is_mul_q) begin
          prod_d = {mul_sum, prod_q[BITS-1:1]};
        end else if (!div_diff[BITS]) begin
          rem_d = div_diff[BITS-1:0];
          quo_d = {quo_q[BITS-2:0], 1'b1};
        end else begin
          rem_d = div_shift[BITS-1:0];
          quo_d = {quo_q[BITS-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_result;
        ready_d  = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A redirect kills whatever is in flight, including a result being registered this edge.
    if (flush) begin
      state_d  = S_IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking only; datapath registers are cleared too so the block is fully defined after reset.
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      code_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      neg_q      <= 1'b0;
      sign_a_q   <= 1'b0;
      div_zero_q <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      a_q        <= a_d;
      b_q        <= b_d;
      prod_q     <= prod_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      neg_q      <= neg_d;
      sign_a_q   <= sign_a_d;
      div_zero_q <= div_zero_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign MulDivAluReady = ready_q;
  assign result         = result_q;

endmodule
